// File: rtl/encoder_4_to_2_rr.sv
// Registered request encoder: picks one active request line (fixed or round-robin priority) and presents its index and one-hot grant.
// Latency: one cycle from the capture edge to o_valid; there is no combinational path from i_req to any output.
// Backpressure: the result holds stable while i_ready=0; on a handshake a new request is captured on the same edge, so there is no bubble.
module encoder_4_to_2_rr #(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_onehot,
  output logic         o_multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ptr_q;
  logic [W-1:0]   idx_q;
  logic [N-1:0]   onehot_q;
  logic           multi_q;
  logic [W-1:0]   base;
  logic [W-1:0]   sel_idx;
  logic           any_req;
  logic           handshake;
  logic           capture;

  assign any_req   = |i_req;
  assign handshake = (state_q == HOLD) && i_ready;

  // A same-edge recapture must already see the pointer advanced past the accepted index.
  assign base = handshake ? idx_q + 1'b1 : ptr_q;

  always_comb begin
    logic         found;
    logic [W-1:0] pos;
    sel_idx = '0;
    found   = 1'b0;
    pos     = '0;
    if (RR) begin
      for (int k = 0; k < N; k++) begin
        pos = base + W'(k);
        if (!found && i_req[pos]) begin
          sel_idx = pos;
          found   = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (i_req[k]) sel_idx = W'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en && any_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_ready) begin
          if (i_en && any_req) capture = 1'b1;
          else                 state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      if (handshake) ptr_q <= idx_q + 1'b1;
      if (capture) begin
        idx_q    <= sel_idx;
        onehot_q <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
        multi_q  <= |(i_req & (i_req - 1'b1));
      end
    end
  end

  assign o_valid  = (state_q == HOLD);
  assign o_idx    = idx_q;
  assign o_onehot = onehot_q;
  assign o_multi  = multi_q;

endmodule

// File: tb/tb_encoder_4_to_2_rr.sv
// Directed bench for encoder_4_to_2_rr: round-robin and fixed-priority instances share one stimulus.
module tb_encoder_4_to_2_rr;

  logic       clk = 1'b0;
  logic       rst, en, ready;
  logic [3:0] req;

  logic       rr_valid, fp_valid, rr_multi, fp_multi;
  logic [1:0] rr_idx, fp_idx;
  logic [3:0] rr_onehot, fp_onehot;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_4_to_2_rr #(.N(4), .RR(1'b1)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_ready(ready),
    .o_valid(rr_valid), .o_idx(rr_idx), .o_onehot(rr_onehot), .o_multi(rr_multi)
  );

  encoder_4_to_2_rr #(.N(4), .RR(1'b0)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_ready(ready),
    .o_valid(fp_valid), .o_idx(fp_idx), .o_onehot(fp_onehot), .o_multi(fp_multi)
  );

  // Reference 2-to-4 decoder used to check the idx/onehot relationship.
  function automatic logic [3:0] dec(input logic [1:0] a);
    logic [3:0] v;
    v = 4'b0000;
    v[a] = 1'b1;
    return v;
  endfunction

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ready = 1'b1; req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if ({rr_valid, rr_idx, rr_onehot, rr_multi} !== 8'b0_00_0000_0) begin
        bad++;
        $display("FAIL reset_rr cycle %0d: got %b want 00000000", c, {rr_valid, rr_idx, rr_onehot, rr_multi});
      end
      total++;
      if ({fp_valid, fp_idx, fp_onehot, fp_multi} !== 8'b0_00_0000_0) begin
        bad++;
        $display("FAIL reset_fp cycle %0d: got %b want 00000000", c, {fp_valid, fp_idx, fp_onehot, fp_multi});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_line();
    logic [3:0] reqs [4];
    reqs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req = reqs[i];
      step();
      total++;
      if ({fp_valid, fp_idx, fp_onehot, fp_multi} !== {1'b1, 2'(i), reqs[i], 1'b0}) begin
        bad++;
        $display("FAIL single_fp req=%b: got %b want %b", reqs[i],
                 {fp_valid, fp_idx, fp_onehot, fp_multi}, {1'b1, 2'(i), reqs[i], 1'b0});
      end
      total++;
      if (dec(fp_idx) !== fp_onehot) begin
        bad++;
        $display("FAIL single_decode idx=%0d: onehot %b want %b", fp_idx, fp_onehot, dec(fp_idx));
      end
    end
    req = 4'b0000;
    step();
    total++;
    if (fp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_zero_req: valid %b want 0", fp_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1'b1; ready = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({rr_valid, rr_idx, rr_onehot, rr_multi} !== {1'b1, 2'(i % 4), dec(2'(i % 4)), 1'b1}) begin
        bad++;
        $display("FAIL rr_cycle %0d: got %b want %b", i,
                 {rr_valid, rr_idx, rr_onehot, rr_multi}, {1'b1, 2'(i % 4), dec(2'(i % 4)), 1'b1});
      end
      total++;
      if ({fp_valid, fp_idx, fp_multi} !== 4'b1_00_1) begin
        bad++;
        $display("FAIL fixed_prio cycle %0d: got %b want 1001", i, {fp_valid, fp_idx, fp_multi});
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; ready = 1'b0; req = 4'b0110;
    step();
    req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({rr_valid, rr_idx, rr_onehot, rr_multi} !== 8'b1_01_0010_1) begin
        bad++;
        $display("FAIL stall_hold cycle %0d: got %b want 10100101", c, {rr_valid, rr_idx, rr_onehot, rr_multi});
      end
      step();
    end
    ready = 1'b1;
    step();
    total++;
    if ({rr_valid, rr_idx, rr_onehot, rr_multi} !== 8'b1_11_1000_0) begin
      bad++;
      $display("FAIL stall_release: got %b want 11110000", {rr_valid, rr_idx, rr_onehot, rr_multi});
    end
    // Accepting idx 3 wraps the pointer to 0.
    req = 4'b1111;
    step();
    total++;
    if (rr_idx !== 2'd0) begin
      bad++;
      $display("FAIL stall_wrap: idx %0d want 0", rr_idx);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; ready = 1'b1; req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (rr_valid !== 1'b0) begin
        bad++;
        $display("FAIL enable_gated cycle %0d: valid %b want 0", c, rr_valid);
      end
    end
    en = 1'b1;
    step();
    total++;
    if ({rr_valid, rr_idx, rr_multi} !== 4'b1_10_0) begin
      bad++;
      $display("FAIL enable_capture: got %b want 1100", {rr_valid, rr_idx, rr_multi});
    end
    en = 1'b0; ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if ({rr_valid, rr_idx} !== 3'b1_10) begin
        bad++;
        $display("FAIL enable_drop_hold cycle %0d: got %b want 110", c, {rr_valid, rr_idx});
      end
    end
    ready = 1'b1;
    step();
    total++;
    if (rr_valid !== 1'b0) begin
      bad++;
      $display("FAIL enable_release: valid %b want 0", rr_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; ready = 1'b1; req = 4'b0001;
    step();
    req = 4'b1000;
    step();
    ready = 1'b0;
    step();
    total++;
    if ({rr_valid, rr_idx} !== 3'b1_11) begin
      bad++;
      $display("FAIL midrst_setup: got %b want 111", {rr_valid, rr_idx});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({rr_valid, rr_idx, rr_onehot, rr_multi} !== 8'b0_00_0000_0) begin
      bad++;
      $display("FAIL midrst_clear: got %b want 00000000", {rr_valid, rr_idx, rr_onehot, rr_multi});
    end
    ready = 1'b1; req = 4'b1001;
    step();
    total++;
    if ({rr_valid, rr_idx, rr_multi} !== 4'b1_00_1) begin
      bad++;
      $display("FAIL midrst_ptr: got %b want 1001", {rr_valid, rr_idx, rr_multi});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1; ready = 1'b1; req = 4'b1010;
    step();
    total++;
    if (rr_idx !== 2'd1) begin
      bad++;
      $display("FAIL b2b_first: idx %0d want 1", rr_idx);
    end
    step();
    total++;
    if ({rr_valid, rr_idx} !== 3'b1_11) begin
      bad++;
      $display("FAIL b2b_second: got %b want 111", {rr_valid, rr_idx});
    end
    step();
    total++;
    if ({rr_valid, rr_idx} !== 3'b1_01) begin
      bad++;
      $display("FAIL b2b_third: got %b want 101", {rr_valid, rr_idx});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; req = 4'b0000;
    test_reset();
    test_single_line();
    test_round_robin();
    test_stall();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
